// File: rtl/midi_pkg.sv
// Shared MIDI constants, message record and status-byte length decoding
// used by the parser and its message FIFO.
package midi_pkg;

    localparam logic [7:0] NOTE_OFF    = 8'h80;
    localparam logic [7:0] NOTE_ON     = 8'h90;
    localparam logic [7:0] POLY_AT     = 8'hA0;
    localparam logic [7:0] CTRL_CHANGE = 8'hB0;
    localparam logic [7:0] PROG_CHANGE = 8'hC0;
    localparam logic [7:0] CHAN_AT     = 8'hD0;
    localparam logic [7:0] PITCH_BEND  = 8'hE0;
    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] TUNE_REQ    = 8'hF6;
    localparam logic [7:0] RT_MIN      = 8'hF8;

    typedef struct packed {
        logic [7:0] status;
        logic [7:0] data1;
        logic [7:0] data2;
    } msg_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SYSEX   = 2'd3
    } parse_state_t;

    // Total message length in bytes including the status byte; 0 = not a message start.
    function automatic logic [1:0] msg_length(input logic [7:0] status);
        logic [1:0] len;
        len = 2'd0;
        if (!status[7]) begin
            len = 2'd0;
        end else if (status >= RT_MIN) begin
            len = 2'd1;
        end else if (status[7:4] == PROG_CHANGE[7:4] || status[7:4] == CHAN_AT[7:4]) begin
            len = 2'd2;
        end else if (status[7:4] != 4'hF) begin
            len = 2'd3;
        end else begin
            case (status[3:0])
                4'h1, 4'h3: len = 2'd2;
                4'h2:       len = 2'd3;
                4'h6:       len = 2'd1;
                default:    len = 2'd0;
            endcase
        end
        return len;
    endfunction

endpackage

// File: rtl/midi_msg_fifo.sv
// First-word-fall-through message FIFO; head is visible whenever not empty,
// and a write is accepted while full if a read happens in the same cycle.
module midi_msg_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_COUNT);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: frames status/data bytes (running status, SysEx skip,
// real-time interleave), filters by channel and queues messages in a FWFT FIFO.
module midi_msg_parser
    import midi_pkg::*;
#(
    parameter int          FIFO_DEPTH    = 16,
    parameter logic [15:0] CHANNEL_MASK  = 16'hFFFF,
    parameter bit          DROP_REALTIME = 1'b0,
    parameter bit          NOTE_OFF_NORM = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [23:0] msg_out,
    output logic [1:0]  msg_len,
    input  logic        rd_en,
    output logic        empty,
    output logic        full,
    output logic        overflow
);

    parse_state_t state_reg;
    logic [7:0]   status_reg;
    logic [7:0]   data1_reg;
    logic [1:0]   len_reg;
    logic         push_reg;
    msg_t         push_msg_reg;
    logic [1:0]   push_len_reg;
    logic         overflow_reg;

    msg_t         done_msg;
    logic         done_keep;
    parse_state_t done_state;
    logic [25:0]  fifo_rd_data;

    // Message that would be completed by the current data byte.
    always_comb begin
        done_msg        = '0;
        done_msg.status = status_reg;
        if (state_reg == WAIT_D2) begin
            done_msg.data1 = data1_reg;
            done_msg.data2 = byte_in;
        end else begin
            done_msg.data1 = byte_in;
            done_msg.data2 = 8'h00;
        end
        if (NOTE_OFF_NORM && status_reg[7:4] == NOTE_ON[7:4] &&
            state_reg == WAIT_D2 && byte_in == 8'h00) begin
            done_msg.status = {NOTE_OFF[7:4], status_reg[3:0]};
            done_msg.data2  = 8'h40;
        end
        done_keep  = (status_reg >= SYSEX_START) || CHANNEL_MASK[status_reg[3:0]];
        // Voice messages keep running status; system common does not.
        done_state = (status_reg < SYSEX_START) ? WAIT_D1 : IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            status_reg   <= 8'h00;
            data1_reg    <= 8'h00;
            len_reg      <= 2'd0;
            push_reg     <= 1'b0;
            push_msg_reg <= '0;
            push_len_reg <= 2'd0;
            overflow_reg <= 1'b0;
        end else begin
            push_reg <= 1'b0;
            if (byte_valid) begin
                if (byte_in >= RT_MIN) begin
                    if (!DROP_REALTIME) begin
                        push_reg     <= 1'b1;
                        push_msg_reg <= '{status: byte_in, data1: 8'h00, data2: 8'h00};
                        push_len_reg <= 2'd1;
                    end
                end else if (byte_in[7]) begin
                    if (byte_in < SYSEX_START) begin
                        status_reg <= byte_in;
                        len_reg    <= msg_length(byte_in);
                        state_reg  <= WAIT_D1;
                    end else if (byte_in == SYSEX_START) begin
                        state_reg <= SYSEX;
                    end else if (byte_in == SYSEX_END) begin
                        if (state_reg == SYSEX) begin
                            state_reg <= IDLE;
                        end
                    end else if (state_reg != SYSEX) begin
                        case (byte_in)
                            8'hF1, 8'hF2, 8'hF3: begin
                                status_reg <= byte_in;
                                len_reg    <= msg_length(byte_in);
                                state_reg  <= WAIT_D1;
                            end
                            TUNE_REQ: begin
                                push_reg     <= 1'b1;
                                push_msg_reg <= '{status: byte_in, data1: 8'h00, data2: 8'h00};
                                push_len_reg <= 2'd1;
                                state_reg    <= IDLE;
                            end
                            default: state_reg <= IDLE;
                        endcase
                    end
                end else begin
                    case (state_reg)
                        WAIT_D1: begin
                            if (len_reg == 2'd3) begin
                                data1_reg <= byte_in;
                                state_reg <= WAIT_D2;
                            end else begin
                                push_reg     <= done_keep;
                                push_msg_reg <= done_msg;
                                push_len_reg <= len_reg;
                                state_reg    <= done_state;
                            end
                        end
                        WAIT_D2: begin
                            push_reg     <= done_keep;
                            push_msg_reg <= done_msg;
                            push_len_reg <= len_reg;
                            state_reg    <= done_state;
                        end
                        default: ;
                    endcase
                end
            end
            if (push_reg && full && !rd_en) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    midi_msg_fifo #(
        .WIDTH (26),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push_reg),
        .wr_data ({push_len_reg, push_msg_reg}),
        .rd_en   (rd_en),
        .rd_data (fifo_rd_data),
        .empty   (empty),
        .full    (full)
    );

    assign msg_out  = fifo_rd_data[23:0];
    assign msg_len  = fifo_rd_data[25:24];
    assign overflow = overflow_reg;

endmodule
